// File: rtl/uart_tx_ctrl.sv
// Purpose: buffers CPU OUT bytes in a small FIFO and serialises each one as an 8N1 frame on tx.
// Latency: a byte written into an empty queue at edge E0 is popped at E1; tx falls right after E1.
// Backpressure: none toward the CPU; a write into a full queue is dropped and sets sticky overflow.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_enable,
  input  logic [7:0] data_in,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  // Queue geometry. The count is one bit wider than the pointers so that
  // "full" and "empty" are distinguishable when the pointers are equal.
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  // Baud counter runs 0..CLKS_PER_BIT-1 within every serial bit.
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q;
  logic [FIFO_AW-1:0]   rd_ptr_q;
  logic [FIFO_AW:0]     cnt_q;
  logic                 ovf_q;

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic drop;
  logic baud_wrap;

  // Pop only from IDLE; a pop on the same edge frees a slot, so a write into
  // a full queue is still accepted in that cycle. Everything else that finds
  // the queue full is dropped.
  always_comb begin
    fifo_full  = (cnt_q == CNT_FULL);
    fifo_empty = (cnt_q == '0);
    pop        = (state_q == IDLE) && !fifo_empty;
    push       = send_enable && (!fifo_full || pop);
    drop       = send_enable && !push;
    baud_wrap  = (baud_q == BAUD_LAST);
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decode. tx is computed one cycle ahead and
  // registered so the pin never sees a combinational path from the inputs.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    // The baud counter only runs while a frame is being sent.
    if (state_q != IDLE) begin
      baud_d = baud_wrap ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (pop) begin
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (baud_wrap) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // LSB-first: the next bit to drive is shift_q[1] before the shift.
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_wrap) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        baud_d  = '0;
      end
    endcase
  end

  // Serial datapath registers: baud counter, bit index, shifter and the pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky overflow: a drop on the same edge as clr_ovf keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all taken straight from registers
  // ---------------------------------------------------------------------------
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign full     = fifo_full;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: instance a uses the default parameters, instance b uses
// CLKS_PER_BIT=2, FIFO_AW=1. Expected bytes are queued at write time; a serial
// receiver per instance pops and compares each frame it sees on tx.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       se0 = 1'b0, clr0 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic       tx0, busy0, full0, ovf0;

  logic       se1 = 1'b0, clr1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       tx1, busy1, full1, ovf1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int aborts = 0;
  int frames0 = 0;
  int frames1 = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         start_q0[$];
  int         start_q1[$];

  logic [7:0] t2_dat [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] t3_dat [5] = '{8'hC3, 8'h3C, 8'h0F, 8'hF0, 8'h81};
  logic [7:0] t6_dat [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

  uart_tx_ctrl #(.CLKS_PER_BIT(16), .FIFO_AW(2)) dut_a (
    .clk(clk), .reset(reset), .send_enable(se0), .data_in(d0), .clr_ovf(clr0),
    .tx(tx0), .busy(busy0), .full(full0), .overflow(ovf0)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(2), .FIFO_AW(1)) dut_b (
    .clk(clk), .reset(reset), .send_enable(se1), .data_in(d1), .clr_ovf(clr1),
    .tx(tx1), .busy(busy1), .full(full1), .overflow(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic txs(input int w);
    return (w == 0) ? tx0 : tx1;
  endfunction

  function automatic logic busys(input int w);
    return (w == 0) ? busy0 : busy1;
  endfunction

  // One CPU write, driven between edges and held across exactly one rising edge.
  // expect_tx queues the byte as something that must later appear on the line.
  task automatic wr(input int w, input logic [7:0] d, input bit expect_tx);
    if (w == 0) begin
      se0 = 1'b1; d0 = d;
      if (expect_tx) exp_q0.push_back(d);
    end else begin
      se1 = 1'b1; d1 = d;
      if (expect_tx) exp_q1.push_back(d);
    end
    @(posedge clk); #1;
    se0 = 1'b0; se1 = 1'b0;
  endtask

  task automatic wait_idle(input int w, input int budget, input string name);
    int n = 0;
    while (busys(w) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, busys(w), 1'b0);
  endtask

  // Serial receiver: on a falling tx, pop the expected byte and check every
  // cycle of the 10-bit frame against it; mid-bit samples rebuild the byte.
  task automatic run_mon(input int w);
    int         cpb;
    int         errs;
    bit         ab;
    logic [7:0] e;
    logic [7:0] rx;
    logic [9:0] fr;
    cpb = (w == 0) ? 16 : 2;
    forever begin
      @(negedge clk);
      if (reset || txs(w) !== 1'b0) continue;
      if (w == 0) start_q0.push_back(cyc); else start_q1.push_back(cyc);
      e = 8'h00;
      if ((w == 0 && exp_q0.size() == 0) || (w == 1 && exp_q1.size() == 0)) begin
        total++; bad++;
        $display("FAIL unexpected_frame inst=%0d: got a start bit, required no frame", w);
      end else if (w == 0) begin
        e = exp_q0.pop_front();
      end else begin
        e = exp_q1.pop_front();
      end
      fr = {1'b1, e, 1'b0};
      errs = 0; ab = 1'b0; rx = 8'h00;
      for (int b = 0; b < 10 && !ab; b++) begin
        for (int c = 0; c < cpb && !ab; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (reset) begin
            ab = 1'b1;
          end else begin
            if (txs(w) !== fr[b]) errs++;
            if (c == cpb / 2 && b >= 1 && b <= 8) rx[b-1] = txs(w);
          end
        end
      end
      if (ab) begin
        aborts++;
      end else begin
        chk($sformatf("frame_byte inst=%0d", w), {24'h0, rx}, {24'h0, e});
        chk($sformatf("frame_shape_errs inst=%0d", w), errs, 0);
        if (w == 0) frames0++; else frames1++;
      end
    end
  endtask

  initial begin
    fork
      run_mon(0);
      run_mon(1);
    join_none
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n_low;
    int fr_before;

    // Reset state, checked while reset is held and before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_tx_a", tx0, 1'b1);     chk("rst_busy_a", busy0, 1'b0);
    chk("rst_full_a", full0, 1'b0); chk("rst_ovf_a", ovf0, 1'b0);
    chk("rst_tx_b", tx1, 1'b1);     chk("rst_busy_b", busy1, 1'b0);
    chk("rst_full_b", full1, 1'b0); chk("rst_ovf_b", ovf1, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 1: single 0x55 frame, 160 cycles, busy from the write until frame end.
    start_q0.delete();
    wr(0, 8'h55, 1'b1);
    t0 = cyc;
    chk("t1_busy_after_write", busy0, 1'b1);
    chk("t1_full", full0, 1'b0);
    repeat (160) @(posedge clk);
    #1;
    chk("t1_busy_last_stop_cycle", busy0, 1'b1);
    @(posedge clk); #1;
    chk("t1_busy_after_frame", busy0, 1'b0);
    chk("t1_tx_idle", tx0, 1'b1);
    chk("t1_frame_count", start_q0.size(), 1);
    chk("t1_start_cycle", start_q0[0], t0 + 1);

    // 2: six back-to-back writes, sixth dropped, five frames 161 cycles apart.
    start_q0.delete();
    for (int i = 0; i < 6; i++) begin
      wr(0, t2_dat[i], i < 5);
      if (i == 4) begin
        chk("t2_full_after_5th", full0, 1'b1);
        chk("t2_ovf_after_5th", ovf0, 1'b0);
      end
      if (i == 5) begin
        chk("t2_ovf_after_6th", ovf0, 1'b1);
        chk("t2_full_after_6th", full0, 1'b1);
      end
    end
    wait_idle(0, 1500, "t2_idle");
    chk("t2_frame_count", start_q0.size(), 5);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("t2_gap_%0d", k), start_q0[k] - start_q0[k-1], 161);
    end

    // 3: clr_ovf alone clears; clr_ovf together with a drop leaves it set.
    chk("t3_ovf_before_clr", ovf0, 1'b1);
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    chk("t3_ovf_cleared", ovf0, 1'b0);
    wr(0, t3_dat[0], 1'b1);
    t0 = cyc;
    for (int i = 1; i < 5; i++) wr(0, t3_dat[i], 1'b1);
    chk("t3_full", full0, 1'b1);
    clr0 = 1'b1;
    wr(0, 8'h7E, 1'b0);
    clr0 = 1'b0;
    chk("t3_ovf_set_wins", ovf0, 1'b1);
    chk("t3_full_kept", full0, 1'b1);
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    chk("t3_ovf_cleared_again", ovf0, 1'b0);

    // 4: write into the full queue on the IDLE pop edge is accepted and sent last.
    while (cyc < t0 + 161) begin
      @(posedge clk); #1;
    end
    chk("t4_full_before_pop", full0, 1'b1);
    wr(0, 8'h99, 1'b1);
    chk("t4_full_after_pop_push", full0, 1'b1);
    chk("t4_ovf_stays_clear", ovf0, 1'b0);
    wait_idle(0, 1500, "t4_idle");

    // 5: reset during data bit 3 of 0xA5 with two bytes queued.
    wr(0, 8'hA5, 1'b1);
    t0 = cyc;
    wr(0, 8'h12, 1'b0);
    wr(0, 8'h34, 1'b0);
    while (cyc < t0 + 73) begin
      @(posedge clk); #1;
    end
    chk("t5_tx_bit3", tx0, 1'b0);
    chk("t5_busy_mid_frame", busy0, 1'b1);
    fr_before = frames0;
    reset = 1'b1;
    #1;
    chk("t5_rst_tx", tx0, 1'b1);
    chk("t5_rst_busy", busy0, 1'b0);
    chk("t5_rst_full", full0, 1'b0);
    chk("t5_rst_ovf", ovf0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_low = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx0 !== 1'b1) n_low++;
    end
    chk("t5_tx_low_cycles_after_rst", n_low, 0);
    chk("t5_no_new_frames", frames0, fr_before);
    chk("t5_aborted_frames", aborts, 1);
    chk("t5_busy_after_rst", busy0, 1'b0);
    @(posedge clk); #1;

    // 6: small instance, 0x80 frame is 20 cycles, then overflow on a 2-deep queue.
    start_q1.delete();
    wr(1, 8'h80, 1'b1);
    t0 = cyc;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_busy_last_stop_cycle", busy1, 1'b1);
    @(posedge clk); #1;
    chk("t6_busy_after_frame", busy1, 1'b0);
    chk("t6_start_cycle", start_q1[0], t0 + 1);
    for (int i = 0; i < 5; i++) begin
      wr(1, t6_dat[i], i < 3);
      if (i == 2) begin
        chk("t6_full_after_3rd", full1, 1'b1);
        chk("t6_ovf_after_3rd", ovf1, 1'b0);
      end
      if (i == 3) chk("t6_ovf_after_4th", ovf1, 1'b1);
      if (i == 4) chk("t6_full_after_5th", full1, 1'b1);
    end
    wait_idle(1, 300, "t6_idle");
    chk("t6_frame_count", start_q1.size(), 4);
    for (int k = 2; k < 4; k++) begin
      chk($sformatf("t6_gap_%0d", k), start_q1[k] - start_q1[k-1], 21);
    end

    // Everything expected must have been seen.
    @(posedge clk); #1;
    chk("end_exp_left_a", exp_q0.size(), 0);
    chk("end_exp_left_b", exp_q1.size(), 0);
    chk("end_frames_a", frames0, 12);
    chk("end_frames_b", frames1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
